// File: rtl/instr_loader.sv
// instr_loader: streams a program into instruction memory over valid/ready, holding the core in reset until loaded.
//
// Ports:
//   Clk       system clock, rising edge
//   Reset     asynchronous active-high reset
//   start     begins a load (honoured only in IDLE or DONE)
//   len       number of words to load, sampled with start
//   abort     returns to IDLE on the next edge, highest priority
//   in_valid  in_data holds a word
//   in_data   9-bit machine word
//   in_ready  a word is accepted this cycle (LOAD only)
//   wr_en     instruction-memory write strobe, one cycle per word
//   wr_addr   write address
//   wr_data   write data
//   busy      high in LOAD
//   done      high in DONE
//   err       sticky: last start asked for more than 2**D words
//   cpu_hold  holds the core in reset; low only in DONE
//   checksum  XOR of all words accepted in the current load
module instr_loader #(
    parameter int D = 10
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    input  logic [D:0]   len,
    input  logic         abort,
    input  logic         in_valid,
    input  logic [8:0]   in_data,
    output logic         in_ready,
    output logic         wr_en,
    output logic [D-1:0] wr_addr,
    output logic [8:0]   wr_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         cpu_hold,
    output logic [8:0]   checksum
);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [D:0] DEPTH = {1'b1, {D{1'b0}}};
    localparam logic [D:0] ONE   = {{D{1'b0}}, 1'b1};
    state_t     state;
    logic [D:0] cnt;
    logic [D:0] len_q;
    logic [D:0] cnt_nxt;
    logic       accept;
    assign in_ready = state == LOAD;
    assign busy     = state == LOAD;
    assign done     = state == DONE;
    assign cpu_hold = state != DONE;
    assign accept   = in_valid && in_ready;
    assign cnt_nxt  = cnt + ONE;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            len_q    <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
            checksum <= '0;
        end else begin
            // write strobe is a single-cycle pulse; only an accept re-arms it
            wr_en <= 1'b0;
            if (abort) begin
                state <= IDLE;
            end else if (state == LOAD) begin
                if (accept) begin
                    wr_en    <= 1'b1;
                    wr_addr  <= cnt[D-1:0];
                    wr_data  <= in_data;
                    checksum <= checksum ^ in_data;
                    cnt      <= cnt_nxt;
                    // leave on the edge that registers the last write
                    if (cnt_nxt == len_q)
                        state <= DONE;
                end
            end else if (start) begin
                if (len > DEPTH) begin
                    err   <= 1'b1;
                    state <= IDLE;
                end else begin
                    err      <= 1'b0;
                    checksum <= '0;
                    cnt      <= '0;
                    len_q    <= len;
                    state    <= len == '0 ? DONE : LOAD;
                end
            end
        end
    end
endmodule
